// File: rtl/sme_rng_dispenser.sv
// Consumer-side front end for the SME random number source: requests a refill,
// captures the wide random bus into a word bank and streams each word exactly once.
module sme_rng_dispenser #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SMAX = 3
) (
    input  logic                                          g_clk,
    input  logic                                          g_resetn,
    output logic                                          g_clk_req,
    output logic                                          rng_update,
    input  logic [(SMAX + SMAX*(SMAX-1)/2)*XLEN-1:0]      rng_in,
    input  logic                                          flush,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [XLEN-1:0]                               out_data,
    output logic [15:0]                                   refills
);

    localparam int unsigned RMAX = SMAX + SMAX*(SMAX-1)/2;
    localparam int unsigned IDXW = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int unsigned CNTW = $clog2(RMAX + 1);
    localparam int unsigned REFW = 16;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_CAP  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   bank_q [RMAX];
    logic [XLEN-1:0]   bank_d [RMAX];
    logic [IDXW-1:0]   rd_idx_q, rd_idx_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [REFW-1:0]   refills_q, refills_d;
    logic [XLEN-1:0]   rd_word;
    logic              fire;

    // Read mux over the bank, selected by the registered read index
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < RMAX; i++) begin
            if (rd_idx_q == IDXW'(i)) begin
                rd_word = bank_q[i];
            end
        end
    end

    assign out_valid  = (state_q == ST_FULL) && (count_q != '0);
    assign out_data   = out_valid ? rd_word : '0;
    assign fire       = out_valid && out_ready;
    assign rng_update = (state_q == ST_REQ);
    assign g_clk_req  = (state_q != ST_FULL) || out_valid;
    assign refills    = refills_q;

    // Next-state logic; flush overrides every state and any same-cycle handshake
    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        count_d   = count_q;
        refills_d = refills_q;
        for (int i = 0; i < RMAX; i++) begin
            bank_d[i] = bank_q[i];
        end

        if (flush) begin
            state_d  = ST_REQ;
            rd_idx_d = '0;
            count_d  = '0;
            for (int i = 0; i < RMAX; i++) begin
                bank_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    state_d = ST_CAP;
                end
                ST_CAP: begin
                    for (int i = 0; i < RMAX; i++) begin
                        bank_d[i] = rng_in[i*XLEN +: XLEN];
                    end
                    count_d  = CNTW'(RMAX);
                    rd_idx_d = '0;
                    if (refills_q != '1) begin
                        refills_d = refills_q + REFW'(1);
                    end
                    state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (fire) begin
                        for (int i = 0; i < RMAX; i++) begin
                            if (rd_idx_q == IDXW'(i)) begin
                                bank_d[i] = '0;
                            end
                        end
                        count_d = count_q - CNTW'(1);
                        // Last word: park the index at 0 instead of stepping past the bank
                        if (count_q == CNTW'(1)) begin
                            rd_idx_d = '0;
                            state_d  = ST_REQ;
                        end else begin
                            rd_idx_d = rd_idx_q + IDXW'(1);
                        end
                    end else if (count_q == '0) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= ST_REQ;
            rd_idx_q  <= '0;
            count_q   <= '0;
            refills_q <= '0;
            for (int i = 0; i < RMAX; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            count_q   <= count_d;
            refills_q <= refills_d;
            for (int i = 0; i < RMAX; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sme_rng_dispenser.sv
// Bench for sme_rng_dispenser: a queue-based reference model checked every cycle,
// a table of reset-release vectors, and directed flush/reset/saturation sequences.
module tb_sme_rng_dispenser;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SMAX = 3;
    localparam int unsigned RMAX = 6;
    localparam int unsigned BW   = RMAX * XLEN;
    localparam int unsigned NV   = 12;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            g_clk_req;
    logic            rng_update;
    logic [BW-1:0]   rng_in = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_data;
    logic [15:0]     refills;

    int total = 0;
    int bad   = 0;

    always #5 g_clk = ~g_clk;

    sme_rng_dispenser #(.XLEN(XLEN), .SMAX(SMAX)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .g_clk_req  (g_clk_req),
        .rng_update (rng_update),
        .rng_in     (rng_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .refills    (refills)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wd(input logic [BW-1:0] p, input int i);
        return p[i*XLEN +: XLEN];
    endfunction

    function automatic logic [BW-1:0] pat_a();
        logic [BW-1:0] p;
        for (int i = 0; i < RMAX; i++) p[i*XLEN +: XLEN] = 32'(i + 1) * 32'h11111111;
        return p;
    endfunction

    function automatic logic [BW-1:0] pat_rnd();
        logic [BW-1:0] p;
        for (int i = 0; i < RMAX; i++) p[i*XLEN +: XLEN] = $urandom;
        return p;
    endfunction

    // Reference model: pending words in a queue, phase 0=request 1=capture 2=serve
    logic [XLEN-1:0] exp_q[$];
    int              m_phase = 0;
    int              m_cnt   = 0;
    int              ref_base = 0;
    logic            chk_v;

    function automatic logic [15:0] exp_ref();
        return (ref_base + m_cnt > 65535) ? 16'hFFFF : 16'(ref_base + m_cnt);
    endfunction

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            exp_q.delete();
            m_phase = 0;
            m_cnt   = 0;
        end else if (flush) begin
            exp_q.delete();
            m_phase = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    for (int i = 0; i < RMAX; i++) exp_q.push_back(rng_in[i*XLEN +: XLEN]);
                    m_cnt++;
                    m_phase = 2;
                end
                default: begin
                    if (out_ready && exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge g_clk) begin
        if (g_resetn) begin
            chk_v = (m_phase == 2) && (exp_q.size() != 0);
            chk("m_upd", 32'(rng_update), 32'(m_phase == 0));
            chk("m_valid", 32'(out_valid), 32'(chk_v));
            if (chk_v) chk("m_data", out_data, exp_q[0]);
            else       chk("m_data0", out_data, 32'd0);
            chk("m_refills", 32'(refills), 32'(exp_ref()));
            chk("m_clkreq", 32'(g_clk_req), 32'((m_phase != 2) || chk_v));
        end
    end

    typedef struct {
        logic        rdy;
        logic        exp_upd;
        logic        exp_vld;
        logic [31:0] exp_data;
        logic [15:0] exp_ref;
    } vec_t;

    vec_t vec[NV];

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic sync_req();
        int n = 0;
        while (m_phase != 0 && n < 40) begin
            step();
            n++;
        end
        chk("sync_upd", 32'(rng_update), 32'd1);
    endtask

    task automatic run_table();
        for (int k = 0; k < NV; k++) begin
            out_ready = vec[k].rdy;
            flush     = 1'b0;
            @(negedge g_clk);
            chk($sformatf("tbl%0d_upd", k), 32'(rng_update), 32'(vec[k].exp_upd));
            chk($sformatf("tbl%0d_vld", k), 32'(out_valid), 32'(vec[k].exp_vld));
            chk($sformatf("tbl%0d_data", k), out_data, vec[k].exp_data);
            chk($sformatf("tbl%0d_ref", k), 32'(refills), 32'(vec[k].exp_ref));
            step();
        end
    endtask

    logic [BW-1:0] p_b, p_c, p_d, p_e, p_f;
    logic [15:0]   ref0;
    int            n_acc, n_upd;

    initial begin
        // Reset release with the 0x11111111..0x66666666 bus and ready held high
        vec[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 16'd0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 16'd0};
        for (int k = 2; k < 8; k++) vec[k] = '{1'b1, 1'b0, 1'b1, 32'(k - 1) * 32'h11111111, 16'd1};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 32'h0, 16'd1};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 16'd1};
        vec[10] = '{1'b1, 1'b0, 1'b1, 32'h11111111, 16'd2};
        vec[11] = '{1'b0, 1'b0, 1'b1, 32'h22222222, 16'd2};

        out_ready = 1'b1;
        rng_in    = pat_a();
        repeat (2) @(posedge g_clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_upd", 32'(rng_update), 32'd1);
        chk("rst_ref", 32'(refills), 32'd0);
        chk("rst_clkreq", 32'(g_clk_req), 32'd1);
        g_resetn = 1'b1;
        run_table();

        // Ready toggling: one delivery per word, in order, held while stalled
        out_ready = 1'b1;
        sync_req();
        p_b = pat_rnd();
        rng_in = p_b;
        step();
        step();
        n_acc = 0;
        n_upd = 0;
        for (int j = 0; j < 12; j++) begin
            out_ready = (j % 2 == 0);
            @(negedge g_clk);
            if (j < 11 && rng_update) n_upd++;
            if (n_acc < 6) begin
                if (out_valid && out_ready) begin
                    chk("tog_word", out_data, wd(p_b, n_acc));
                    n_acc++;
                end else if (!out_ready) begin
                    chk("tog_hold", out_data, wd(p_b, n_acc));
                end
            end
            step();
        end
        chk("tog_nacc", 32'(n_acc), 32'd6);
        chk("tog_nupd", 32'(n_upd), 32'd0);

        // Flush together with an accepted handshake on the third word
        out_ready = 1'b1;
        sync_req();
        p_c = pat_rnd();
        rng_in = p_c;
        step();
        step();
        step();
        step();
        flush = 1'b1;
        @(negedge g_clk);
        chk("fl_pre", out_data, wd(p_c, 2));
        step();
        flush = 1'b0;
        p_d = pat_rnd();
        rng_in = p_d;
        @(negedge g_clk);
        chk("fl_v1", 32'(out_valid), 32'd0);
        chk("fl_u1", 32'(rng_update), 32'd1);
        step();
        step();
        @(negedge g_clk);
        chk("fl_v3", 32'(out_valid), 32'd1);
        chk("fl_d3", out_data, wd(p_d, 0));

        // Flush during capture: capture discarded, refill count untouched
        sync_req();
        p_e = pat_rnd();
        rng_in = p_e;
        ref0 = exp_ref();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        p_f = pat_rnd();
        rng_in = p_f;
        @(negedge g_clk);
        chk("fcap_upd", 32'(rng_update), 32'd1);
        chk("fcap_ref", 32'(refills), 32'(ref0));
        step();
        step();
        @(negedge g_clk);
        chk("fcap_data", out_data, wd(p_f, 0));
        chk("fcap_ref2", 32'(refills), 32'(16'(ref0 + 16'd1)));

        // Bus changes every cycle; only capture-cycle values may be delivered
        for (int j = 0; j < 40; j++) begin
            rng_in    = pat_rnd();
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Asynchronous reset after two of six words
        out_ready = 1'b1;
        sync_req();
        rng_in = pat_a();
        step();
        step();
        step();
        step();
        #2;
        g_resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_upd", 32'(rng_update), 32'd1);
        chk("arst_ref", 32'(refills), 32'd0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        run_table();

        // Refill counter saturation
        out_ready = 1'b1;
        sync_req();
        ref_base = 32'hFFFE - m_cnt;
        force dut.refills_q = 16'hFFFE;
        #1;
        release dut.refills_q;
        for (int r = 0; r < 3; r++) begin
            step();
            sync_req();
        end
        step();
        step();
        @(negedge g_clk);
        chk("sat_ref", 32'(refills), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sme_rng_dispenser.md
# sme_rng_dispenser

Consumer-side front end for the SME random number source. Drives the source's `update` request, captures each fresh `RMAX*XLEN`-bit random bus into a word bank, and hands words one at a time to SME functional units over a valid/ready stream. Every captured random word is delivered at most once. Sits between the SME RNG and the masked-operation datapath.

## Interface
- `XLEN`, default 32: width of one delivered random word.
- `SMAX`, default 3: maximum share count. Derived `RMAX = SMAX + SMAX*(SMAX-1)/2` is the number of words per refill (6 at defaults).
- `g_clk`, in, 1: clock. One clock domain only.
- `g_resetn`, in, 1: reset. Asynchronous and active-low.
- `g_clk_req`, out, 1: high whenever the FSM is not in `FULL`, or `out_valid` is high.
- `rng_update`, out, 1: connects to the source's `update` input. Source state advances on the clock edge where this signal is high.
- `rng_in`, in, `RMAX*XLEN`: source output bus; word `i` is bits `[i*XLEN +: XLEN]`.
- `flush`, in, 1: discard all unconsumed words and refill (context switch or key change).
- `out_valid`, out, 1: `out_data` holds an unused random word.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, `XLEN`: random word. Forced to 0 when `out_valid` is 0.
- `refills`, out, 16: saturating count of completed captures (debug).

## Operation
- State: `bank[RMAX]` of `XLEN`-bit words, `rd_idx` (0..RMAX-1), `count` (0..RMAX), and the FSM.
- FSM states:
  - `REQ`: `rng_update = 1` for exactly this cycle. Next state is `CAP`.
  - `CAP`: `rng_update = 0`. Latch `bank <= rng_in`, `count <= RMAX`, `rd_idx <= 0`, `refills <= sat(refills+1)`. Next state is `FULL`.
  - `FULL`: serve words. When `count` reaches 0, next state is `REQ`.
- Delivery:
  - `out_valid = (state == FULL) && (count != 0)`.
  - `out_data = bank[rd_idx]` when valid.
  - On `out_valid && out_ready`: `rd_idx++`, `count--`, and the consumed bank entry is cleared to 0.
- No word is ever presented twice. No capture happens without a preceding `REQ` cycle.
- `flush` has priority over everything in every state:
  - next state is `REQ`, `count <= 0`, `rd_idx <= 0`, bank cleared;
  - a handshake in the same cycle is ignored, and the word is not counted as consumed;
  - a flush during `CAP` discards that capture and does not increment `refills`.
- Consumption of the last word (`count` 1 -> 0) moves the FSM to `REQ` on the next edge.
- Width rules: `refills` saturates at 16'hFFFF. `rd_idx` never wraps past `RMAX-1`, because `count` gates it.
- Reset values:
  - FSM = `REQ`, `count = 0`, `rd_idx = 0`, bank = 0, `refills = 0`;
  - outputs: `rng_update = 1` in the first cycle after reset release, `out_valid = 0`, `out_data = 0`, `g_clk_req = 1`.
- Reset mid-operation: immediately returns to the reset values. Words already in the bank are lost, never delivered.

## Timing
- Refill latency: `REQ` in cycle t, `CAP` in t+1, `out_valid` first high in t+2.
- `rng_in` is sampled only in `CAP`, i.e. one cycle after `rng_update` was high. `rng_in` in any other cycle is ignored.
- Sustained throughput with `out_ready` held high: `RMAX` words per `RMAX+2` cycles (6 per 8 at defaults).
- After the last accept in cycle t, `REQ` is in t+1 and the next `out_valid` is in t+3.
- `out_data` is registered-bank driven and combinationally muxed by `rd_idx`. There is no combinational path from `out_ready` to `out_valid` or `out_data`.
- `flush` in cycle t: `out_valid` is 0 from t+1, `rng_update` is high in t+1, `out_valid` is high again in t+3.

## Test plan
- Reset release with `rng_in` = words 0x11111111..0x66666666 and `out_ready = 1`:
  - `rng_update` high only in cycle 0, capture in cycle 1;
  - `out_data` = 0x11111111..0x66666666 in cycles 2..7;
  - `rng_update` high in cycle 8; `refills = 1`, then 2 after the next capture.
- `out_ready` toggling 1,0,1,0:
  - each word delivered exactly once, in index order;
  - `out_data` holds steady while `out_ready = 0`;
  - no `rng_update` until the 6th accept.
- `flush` asserted together with an accepted handshake on word 3:
  - word 3 is not counted;
  - `out_valid` is 0 next cycle, `rng_update` follows, and new bank contents appear 3 cycles after `flush`.
- `flush` during `CAP`:
  - `refills` is unchanged;
  - a second `REQ` occurs, and the data delivered comes from the following capture only.
- `rng_in` changed in every cycle except `CAP`: delivered words equal the `CAP`-cycle values only.
- `g_resetn` dropped asynchronously mid-delivery (after 2 of 6 words): `out_valid` and `out_data` go to 0 immediately; after release the sequence of the first scenario repeats.
- Force `refills` to 0xFFFE, then run 3 refills: it reads 0xFFFF and stays there.
